// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC grid sequencer.
// Holds the default geometry and widths, the controller state type, and
// small index helpers used to address packed NxN matrices and to size the
// step counter.
package systolic_pkg;

  localparam int unsigned N_DEFAULT         = 3;
  localparam int unsigned DW_DEFAULT        = 16;
  localparam int unsigned AW_DEFAULT        = 32;
  localparam int unsigned DRAIN_CYC_DEFAULT = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } ctrl_state_t;

  // Flat element index of (r,c) in a row-major packed NxN matrix.
  function automatic int unsigned elem_off(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n);
    return r * n + c;
  endfunction

  // Bits needed for a counter that must reach both the last feed step
  // (2N-2) and the last drain cycle (DRAIN_CYC-1).
  function automatic int unsigned ctr_width(input int unsigned n,
                                            input int unsigned drain);
    int unsigned m;
    m = (2 * n - 1 > drain) ? 2 * n - 1 : drain;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Diagonal skew generator for one side of the systolic grid.
// Ports:
//   mat       in  N*N*DW  latched matrix, element (r,c) at [(r*N+c)*DW +: DW]
//   step      in  TW      feed step t
//   col_major in  1       0: lane k = mat[k][t-k] (rows, west side)
//                         1: lane k = mat[t-k][k] (columns, north side)
//   lanes     out N*DW    lane k at [k*DW +: DW]; zero outside the diagonal
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned TW = 3
) (
  input  logic [N*N*DW-1:0] mat,
  input  logic [TW-1:0]     step,
  input  logic              col_major,
  output logic [N*DW-1:0]   lanes
);

  always_comb begin
    lanes = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(step) >= k && 32'(step) - k < N) begin
        if (col_major)
          lanes[k*DW +: DW] = mat[elem_off(32'(step) - k, k, N)*DW +: DW];
        else
          lanes[k*DW +: DW] = mat[elem_off(k, 32'(step) - k, N)*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic MAC grid.
// Accepts an operand pair over in_valid/in_ready, clears the PE accumulators
// for one cycle, streams skewed A rows (west) and B columns (north) for 2N-1
// steps, waits DRAIN_CYC cycles for the grid to settle, then captures the
// accumulators and holds them on out_valid/out_ready.
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   in_valid/in_ready   job handshake; a_mat/b_mat latched on accept
//   west_feed/north_feed registered lane inputs to the grid
//   pe_clear            accumulator clear, high only in CLEAR
//   res_in              grid accumulator outputs
//   out_valid/out_ready result handshake; res_out holds the captured grid
//   busy                high whenever not IDLE
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned N         = N_DEFAULT,
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned AW        = AW_DEFAULT,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*N*DW-1:0] a_mat,
  input  logic [N*N*DW-1:0] b_mat,
  output logic [N*DW-1:0]   west_feed,
  output logic [N*DW-1:0]   north_feed,
  output logic              pe_clear,
  input  logic [N*N*AW-1:0] res_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] res_out,
  output logic              busy
);

  localparam int unsigned   TW         = ctr_width(N, DRAIN_CYC);
  localparam logic [TW-1:0] FEED_LAST  = TW'(2 * N - 2);
  localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYC - 1);

  ctrl_state_t       state, state_next;
  logic [TW-1:0]     t, t_next;
  logic [N*N*DW-1:0] a_lat, b_lat;
  logic [N*DW-1:0]   west_lanes, north_lanes;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign pe_clear = (state == CLEAR);

  always_comb begin
    state_next = state;
    t_next     = t;
    unique case (state)
      IDLE: if (in_valid) begin
        state_next = CLEAR;
        t_next     = '0;
      end
      CLEAR: begin
        state_next = FEED;
        t_next     = '0;
      end
      FEED: if (t == FEED_LAST) begin
        state_next = DRAIN;
        t_next     = '0;
      end else begin
        t_next = t + 1'b1;
      end
      DRAIN: if (t == DRAIN_LAST) begin
        state_next = DONE;
        t_next     = '0;
      end else begin
        t_next = t + 1'b1;
      end
      DONE: if (out_ready) begin
        state_next = IDLE;
        t_next     = '0;
      end
      default: begin
        state_next = IDLE;
        t_next     = '0;
      end
    endcase
  end

  // Feeders look at the upcoming step so the registered lanes carry the
  // step-t values for the entire cycle in which the FSM sits at step t.
  systolic_skew_feeder #(.N(N), .DW(DW), .TW(TW)) u_west (
    .mat       (a_lat),
    .step      (t_next),
    .col_major (1'b0),
    .lanes     (west_lanes)
  );

  systolic_skew_feeder #(.N(N), .DW(DW), .TW(TW)) u_north (
    .mat       (b_lat),
    .step      (t_next),
    .col_major (1'b1),
    .lanes     (north_lanes)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      t          <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      west_feed  <= '0;
      north_feed <= '0;
      out_valid  <= 1'b0;
      res_out    <= '0;
    end else begin
      state <= state_next;
      t     <= t_next;
      if (state == IDLE && in_valid) begin
        a_lat <= a_mat;
        b_lat <= b_mat;
      end
      west_feed  <= (state_next == FEED) ? west_lanes  : '0;
      north_feed <= (state_next == FEED) ? north_lanes : '0;
      if (state == DRAIN && t == DRAIN_LAST)
        res_out <= res_in;
      out_valid <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Testbench for systolic_ctrl: drives jobs, attaches a behavioural model of
// the output-stationary PE grid, and checks results against a direct matrix
// product, plus timing, skew, backpressure, reset and back-to-back behaviour.
module tb_systolic_ctrl;

  localparam int N         = 3;
  localparam int DW        = 16;
  localparam int AW        = 32;
  localparam int DRAIN_CYC = 6;
  localparam int LAT       = 1 + (2 * N - 1) + DRAIN_CYC;

  typedef logic [N*N*DW-1:0] mat_t;
  typedef logic [N*N*AW-1:0] res_t;
  typedef logic [N*DW-1:0]   lane_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  in_valid = 1'b0, in_ready;
  mat_t  a_mat = '0, b_mat = '0;
  lane_t west_feed, north_feed;
  logic  pe_clear;
  res_t  res_in;
  logic  out_valid, out_ready = 1'b1;
  res_t  res_out;
  logic  busy;

  int n_cmp  = 0;
  int n_fail = 0;

  lane_t wlog[64];
  lane_t nlog[64];

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .DW(DW), .AW(AW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_mat      (a_mat),
    .b_mat      (b_mat),
    .west_feed  (west_feed),
    .north_feed (north_feed),
    .pe_clear   (pe_clear),
    .res_in     (res_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_out    (res_out),
    .busy       (busy)
  );

  // Grid model: PE(i,j) sees west lane i delayed by j cycles and north
  // lane j delayed by i cycles, accumulating their product each cycle.
  logic [AW-1:0] acc[N][N];
  logic [DW-1:0] wh[N][N];
  logic [DW-1:0] nh[N][N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      wh[0][i] <= west_feed[i*DW +: DW];
      nh[0][i] <= north_feed[i*DW +: DW];
      for (int d = 1; d < N; d++) begin
        wh[d][i] <= wh[d-1][i];
        nh[d][i] <= nh[d-1][i];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (pe_clear) acc[i][j] <= '0;
        else acc[i][j] <= acc[i][j] +
          AW'(j == 0 ? west_feed[i*DW +: DW] : wh[j-1][i]) *
          AW'(i == 0 ? north_feed[j*DW +: DW] : nh[i-1][j]);
  end

  always_comb begin
    res_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        res_in[(i*N+j)*AW +: AW] = acc[i][j];
  end

  function automatic res_t matmul(input mat_t a, input mat_t b);
    res_t r;
    logic [AW-1:0] s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < N; k++)
          s = s + AW'(a[(i*N+k)*DW +: DW]) * AW'(b[(k*N+j)*DW +: DW]);
        r[(i*N+j)*AW +: AW] = s;
      end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t m;
    for (int e = 0; e < N*N; e++) m[e*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = DW'(1);
    return m;
  endfunction

  // Expected skewed lanes at feed step t, straight from the lane rules.
  function automatic lane_t exp_west(input mat_t a, input int t);
    lane_t r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*DW +: DW] = a[(i*N+t-i)*DW +: DW];
    return r;
  endfunction

  function automatic lane_t exp_north(input mat_t b, input int t);
    lane_t r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*DW +: DW] = b[((t-j)*N+j)*DW +: DW];
    return r;
  endfunction

  // Submits one job and monitors it until out_valid rises. Sample k is taken
  // #1 after the k-th rising edge following the accept edge.
  task automatic run_job(input mat_t a, input mat_t b, output int lat,
                         output int clr_first, output int clr_cnt,
                         output bit timed_out);
    int g;
    lat = -1; clr_first = -1; clr_cnt = 0; timed_out = 1'b0; g = 0;
    @(negedge clk);
    a_mat = a; b_mat = b; in_valid = 1'b1;
    while (!in_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      timed_out = 1'b1;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      wlog[k] = west_feed;
      nlog[k] = north_feed;
      if (pe_clear) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = k;
      end
      if (out_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if ({in_ready, busy, out_valid, pe_clear} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready/busy/ov/clr=%b want 1000",
               {in_ready, busy, out_valid, pe_clear});
    end
    n_cmp++;
    if (west_feed !== '0 || north_feed !== '0) begin
      n_fail++;
      $display("FAIL reset_feeds: got west=%h north=%h want 0", west_feed, north_feed);
    end
    n_cmp++;
    if (res_out !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got %h want 0", res_out);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_identity();
    mat_t a, b; res_t e;
    int lat, cf, cc; bit to;
    a = ident();
    for (int x = 0; x < N*N; x++) b[x*DW +: DW] = DW'(x + 1);
    for (int x = 0; x < N*N; x++) e[x*AW +: AW] = AW'(x + 1);
    out_ready = 1'b1;
    run_job(a, b, lat, cf, cc, to);
    n_cmp++;
    if (to || lat != LAT) begin
      n_fail++;
      $display("FAIL ident_latency: got %0d (timeout=%0d) want %0d", lat, to, LAT);
    end
    n_cmp++;
    if (res_out !== e) begin
      n_fail++;
      $display("FAIL ident_result: got %h want %h", res_out, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_constant();
    mat_t a, b;
    int lat, cf, cc; bit to;
    for (int x = 0; x < N*N; x++) begin
      a[x*DW +: DW] = DW'(2);
      b[x*DW +: DW] = DW'(3);
    end
    run_job(a, b, lat, cf, cc, to);
    n_cmp++;
    if (to || cf != 0 || cc != 1) begin
      n_fail++;
      $display("FAIL const_pe_clear: got first=%0d count=%0d want first=0 count=1", cf, cc);
    end
    for (int x = 0; x < N*N; x++) begin
      n_cmp++;
      if (res_out[x*AW +: AW] !== AW'(18)) begin
        n_fail++;
        $display("FAIL const_elem%0d: got %0d want 18", x, res_out[x*AW +: AW]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_skew();
    mat_t a, b;
    int lat, cf, cc; bit to;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a[(r*N+c)*DW +: DW] = DW'(10*r + c);
        b[(r*N+c)*DW +: DW] = DW'(100*r + c);
      end
    run_job(a, b, lat, cf, cc, to);
    n_cmp++;
    if (to || wlog[3] !== {DW'(20), DW'(11), DW'(2)}) begin
      n_fail++;
      $display("FAIL skew_west_t2: got %h want %h", wlog[3], {DW'(20), DW'(11), DW'(2)});
    end
    n_cmp++;
    if (to || nlog[3] !== {DW'(2), DW'(101), DW'(200)}) begin
      n_fail++;
      $display("FAIL skew_north_t2: got %h want %h", nlog[3], {DW'(2), DW'(101), DW'(200)});
    end
    n_cmp++;
    if (wlog[1][DW +: 2*DW] !== '0 || nlog[1][DW +: 2*DW] !== '0) begin
      n_fail++;
      $display("FAIL skew_t0_upper: got west=%h north=%h want lanes1,2=0", wlog[1], nlog[1]);
    end
    // Full pattern on a random job: CLEAR/DRAIN zero, FEED follows the skew.
    a = rand_mat(); b = rand_mat();
    run_job(a, b, lat, cf, cc, to);
    for (int k = 0; k < LAT; k++) begin
      n_cmp++;
      if (to || wlog[k] !== ((k >= 1 && k <= 2*N-1) ? exp_west(a, k-1) : lane_t'(0)) ||
          nlog[k] !== ((k >= 1 && k <= 2*N-1) ? exp_north(b, k-1) : lane_t'(0))) begin
        n_fail++;
        $display("FAIL skew_cycle%0d: got west=%h north=%h want west=%h north=%h", k,
                 wlog[k], nlog[k],
                 (k >= 1 && k <= 2*N-1) ? exp_west(a, k-1) : lane_t'(0),
                 (k >= 1 && k <= 2*N-1) ? exp_north(b, k-1) : lane_t'(0));
      end
    end
    n_cmp++;
    if (res_out !== matmul(a, b)) begin
      n_fail++;
      $display("FAIL skew_rand_result: got %h want %h", res_out, matmul(a, b));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    mat_t a, b, a2, b2; res_t e;
    int lat, cf, cc; bit to;
    a = rand_mat(); b = rand_mat(); a2 = rand_mat(); b2 = rand_mat();
    e = matmul(a, b);
    out_ready = 1'b0;
    run_job(a, b, lat, cf, cc, to);
    n_cmp++;
    if (to || res_out !== e) begin
      n_fail++;
      $display("FAIL bp_first_result: got %h want %h", res_out, e);
    end
    a_mat = a2; b_mat = b2; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          pe_clear !== 1'b0 || res_out !== e) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got ov=%b rdy=%b busy=%b clr=%b res=%h want 1 0 1 0 %h",
                 c, out_valid, in_ready, busy, pe_clear, res_out, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    run_job(a2, b2, lat, cf, cc, to);
    n_cmp++;
    if (to || lat != LAT || res_out !== matmul(a2, b2)) begin
      n_fail++;
      $display("FAIL bp_second_job: got lat=%0d res=%h want lat=%0d res=%h",
               lat, res_out, LAT, matmul(a2, b2));
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mat_t i3; res_t e;
    int lat, cf, cc, g; bit to;
    g = 0;
    @(negedge clk);
    a_mat = rand_mat(); b_mat = rand_mat(); in_valid = 1'b1;
    while (!in_ready && g < 60) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (west_feed !== '0 || north_feed !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b1 || pe_clear !== 1'b0 || res_out !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got west=%h north=%h ov=%b busy=%b rdy=%b clr=%b res=%h want idle zeros",
               west_feed, north_feed, out_valid, busy, in_ready, pe_clear, res_out);
    end
    @(negedge clk);
    rst = 1'b1;
    i3 = ident();
    e = '0;
    for (int i = 0; i < N; i++) e[(i*N+i)*AW +: AW] = AW'(1);
    run_job(i3, i3, lat, cf, cc, to);
    n_cmp++;
    if (to || res_out !== e) begin
      n_fail++;
      $display("FAIL midreset_next_job: got %h want %h", res_out, e);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    mat_t ja[3], jb[3];
    int acc_at[3], hs_at[3];
    int ji, oi;
    for (int j = 0; j < 3; j++) begin
      ja[j] = rand_mat(); jb[j] = rand_mat();
      acc_at[j] = -100; hs_at[j] = -100;
    end
    ji = 0; oi = 0;
    out_ready = 1'b1;
    @(negedge clk);
    a_mat = ja[0]; b_mat = jb[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 200 && oi < 3; cyc++) begin
      if (in_valid && in_ready && ji < 3) begin
        acc_at[ji] = cyc;
        ji++;
      end
      if (out_valid && out_ready && oi < 3) begin
        n_cmp++;
        if (res_out !== matmul(ja[oi], jb[oi])) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h want %h", oi, res_out, matmul(ja[oi], jb[oi]));
        end
        hs_at[oi] = cyc;
        oi++;
      end
      @(negedge clk);
      if (ji < 3) begin
        a_mat = ja[ji]; b_mat = jb[ji];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (oi != 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d results want 3", oi);
    end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (hs_at[j] - acc_at[j] != LAT + 1) begin
        n_fail++;
        $display("FAIL b2b_latency%0d: got %0d want %0d", j, hs_at[j] - acc_at[j], LAT + 1);
      end
    end
    for (int j = 1; j < 3; j++) begin
      n_cmp++;
      if (acc_at[j] != hs_at[j-1] + 1) begin
        n_fail++;
        $display("FAIL b2b_accept%0d: got cycle %0d want %0d", j, acc_at[j], hs_at[j-1] + 1);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_identity();
    test_constant();
    test_skew();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
